// File: rtl/tx_arbiter_pkg.sv
// Shared types and constants for the framed UART transmit arbiter.
package tx_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_GAP,
        ST_CSUM,
        ST_FIN
    } state_e;

    localparam int         MAX_LEN         = 64;
    localparam logic [3:0] HDR_TAG_DEFAULT = 4'hA;

    function automatic logic [6:0] clamp_len(input logic [6:0] len);
        return (len > 7'(MAX_LEN)) ? 7'(MAX_LEN) : len;
    endfunction

endpackage

// File: rtl/tx_arbiter_if.sv
// Requester / UART side bundle of the transmit arbiter.
interface tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ*7-1:0] req_len;
    logic [5:0]        rd_addr;
    logic [NREQ*8-1:0] rd_data;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              txBusy;
    logic              txStart;
    logic [7:0]        txData;

    modport slave (
        input  req, req_len, rd_data, txBusy,
        output rd_addr, gnt, done, txStart, txData
    );

    modport master (
        output req, req_len, rd_data, txBusy,
        input  rd_addr, gnt, done, txStart, txData
    );
endinterface

// File: rtl/tx_arbiter_rr_select.sv
// Combinational round-robin picker: first pending requester after the last owner.
module rr_select #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [2:0]      last_i,
    output logic [NREQ-1:0] gnt_o
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IW'((int'(last_i) + i) % NREQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/tx_arbiter.sv
// Arbitrates NREQ frame sources onto one UART: header, payload, XOR checksum.
module tx_arbiter
    import tx_arbiter_pkg::*;
#(
    parameter int         NREQ    = 4,
    parameter logic [3:0] HDR_TAG = HDR_TAG_DEFAULT
) (
    input  logic         clk,
    input  logic         reset_n,
    tx_arbiter_if.slave  bus
);
    state_e          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] done_q;
    logic            txstart_q;
    logic [7:0]      txdata_q;
    logic [5:0]      rd_addr_q;
    logic [2:0]      last_q;
    logic [2:0]      owner_q;
    logic [7:0]      xor_q;
    logic [6:0]      idx_q;
    logic [6:0]      len_q;
    logic            csum_sent_q;

    logic [NREQ-1:0] gnt_d;
    logic [2:0]      id_d;
    logic [6:0]      len_d;
    logic [7:0]      byte_d;
    logic [7:0]      hdr_d;

    rr_select #(.NREQ(NREQ)) u_rr (
        .req_i  (bus.req),
        .last_i (last_q),
        .gnt_o  (gnt_d)
    );

    always_comb begin
        id_d   = '0;
        len_d  = '0;
        byte_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_d[i]) begin
                id_d  = 3'(i);
                len_d = bus.req_len[i*7 +: 7];
            end
            if (owner_q == 3'(i)) byte_d = bus.rd_data[i*8 +: 8];
        end
    end

    assign hdr_d = {HDR_TAG, 1'b0, id_d};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            txstart_q   <= 1'b0;
            txdata_q    <= '0;
            rd_addr_q   <= '0;
            last_q      <= 3'(NREQ - 1);
            owner_q     <= '0;
            xor_q       <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            csum_sent_q <= 1'b0;
        end else begin
            done_q    <= '0;
            txstart_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|bus.req) state_q <= ST_GRANT;
                end
                ST_GRANT: begin
                    // A requester may have withdrawn between IDLE and GRANT.
                    if (|gnt_d) begin
                        gnt_q       <= gnt_d;
                        owner_q     <= id_d;
                        len_q       <= clamp_len(len_d);
                        txdata_q    <= hdr_d;
                        xor_q       <= hdr_d;
                        idx_q       <= '0;
                        csum_sent_q <= 1'b0;
                        state_q     <= ST_SEND;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (!bus.txBusy) begin
                        txstart_q <= 1'b1;
                        state_q   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (idx_q < len_q)     state_q <= ST_FETCH;
                    else if (!csum_sent_q) state_q <= ST_CSUM;
                    else                   state_q <= ST_FIN;
                end
                ST_FETCH: begin
                    rd_addr_q <= idx_q[5:0];
                    state_q   <= ST_LOAD;
                end
                ST_LOAD: begin
                    txdata_q <= byte_d;
                    xor_q    <= xor_q ^ byte_d;
                    idx_q    <= idx_q + 7'd1;
                    state_q  <= ST_SEND;
                end
                ST_CSUM: begin
                    txdata_q    <= xor_q;
                    csum_sent_q <= 1'b1;
                    state_q     <= ST_SEND;
                end
                ST_FIN: begin
                    done_q  <= gnt_q;
                    last_q  <= owner_q;
                    gnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.txStart = txstart_q;
    assign bus.txData  = txdata_q;
    assign bus.rd_addr = rd_addr_q;

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter HDR_TAG, default 4'hA, upper nibble of every frame header byte.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester level: frame pending; held high until done.
REQ-006 req_len  input  NREQ*7  per-requester payload byte count, 0..64; sampled at grant.
REQ-007 rd_addr  output  6  payload byte index presented to the granted requester.
REQ-008 rd_data  input  NREQ*8  per-requester byte at rd_addr, valid one clk after rd_addr changes.
REQ-009 gnt  output  NREQ  one-hot, the current owner; all zero when idle.
REQ-010 done  output  NREQ  one-clk pulse on the owner's bit after its checksum byte is accepted.
REQ-011 txBusy  input  1  UART transmitter busy.
REQ-012 txStart  output  1  one-clk pulse: launch txData.
REQ-013 txData  output  8  byte to transmit, stable from the txStart pulse until the next txStart.

Function
REQ-014 The frame SHALL be: header {HDR_TAG, 1'b0, id[2:0]}, then payload bytes 0..len-1, then checksum (XOR of header and all payload bytes).
REQ-015 req_len > 64 SHALL be clamped to 64; len 0 SHALL send header and checksum only.
REQ-016 The FSM SHALL have states IDLE, GRANT, FETCH, LOAD, SEND, GAP, CSUM, FIN.
REQ-017 IDLE: if any req is high, go to GRANT next clk; otherwise stay, with gnt=0.
REQ-018 GRANT: select round-robin, starting at the index after the last owner (index 0 after reset); assert gnt; latch the clamped len; load the header into txData; clear the byte index; go to SEND.
REQ-019 SEND: when txBusy=0, pulse txStart for one clk; go to GAP.
REQ-020 GAP: ignore txBusy for exactly one clk. Then go to FETCH if payload bytes remain, to CSUM if the checksum is unsent, otherwise to FIN.
REQ-021 FETCH: drive rd_addr=index; go to LOAD next clk.
REQ-022 LOAD: latch rd_data[owner] into txData and into the running XOR; increment the index; go to SEND.
REQ-023 CSUM: load the running XOR into txData; go to SEND.
REQ-024 FIN: pulse done[owner]; record the owner as last; clear gnt; go to IDLE.
REQ-025 A requester dropping req mid-frame SHALL NOT abort the frame; the frame completes with whatever rd_data supplies.
REQ-026 Requests arriving during a frame SHALL wait; the minimum gap between frames is 2 clk (FIN, IDLE).
REQ-027 The running XOR SHALL be 8 bits; the byte index SHALL be 7 bits so that len=64 does not wrap.
REQ-028 txStart SHALL never be asserted while txBusy=1 in the same clk.

Reset
REQ-029 On reset_n=0, asynchronously: state=IDLE, gnt=0, done=0, txStart=0, txData=0, rd_addr=0, last owner=NREQ-1, XOR=0, index=0.
REQ-030 Reset mid-frame SHALL abandon the frame with no done pulse; the first post-reset grant SHALL go to the lowest pending index.

Structure
REQ-031 A shared package SHALL hold the state enum, MAX_LEN=64, and the header tag default.
REQ-032 The round-robin selector SHALL be one sub-module, rr_select (inputs: req vector and last owner; output: one-hot next owner), purely combinational.

Verification
REQ-033 req[1]=1, len=3, bytes 11,22,33, txBusy low -> serial bytes A1,11,22,33,A1^11^22^33; done[1] pulses once; gnt[1] high throughout.
REQ-034 req[0] and req[2] raised in the same clk after reset -> frame 0 first, then frame 2; with req[0] held, the next grant goes to 0 only after 2.
REQ-035 len=0 on req[3] -> bytes A3, A3; done[3] pulses.
REQ-036 len=100 -> exactly 64 payload bytes; rd_addr runs 0..63 with no wrap.
REQ-037 txBusy held high for 50 clk after each txStart -> no txStart while busy; byte order preserved.
REQ-038 reset_n low during payload byte 5 -> all outputs reach reset values at once; no done; a new frame restarts with the header.
